uart_rx_fifo: RTL

Parametrised UART receiver with an integrated receive FIFO. It is the successor to the single-byte ready/ack receiver feeding the CPU's `IN A` path. It adds:
- configurable baud divider, data width and FIFO depth;
- input synchronisation and start-bit glitch rejection;
- framing and overflow error reporting;
- a valid/ready stream interface, so the CPU no longer drops bytes while busy.

---
 rtl/uart_rx_fifo.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (2-flop sync, start-glitch reject, framing/parity check) feeding a first-word-fall-through FIFO.
// Latency: byte is written on the stop-bit sample edge; m_valid/fill reflect it one edge later.
// Backpressure: none toward the line; m_ready pops the FIFO, bytes arriving while full are dropped and set overflow.
// Build option: define UART_RX_PARITY_EN to expect one parity bit before the stop bit (sense chosen by PARITY_ODD).
module uart_rx_fifo #(
  parameter int CLK_DIV    = 1250,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx_pin,
  output logic [DATA_BITS-1:0]        m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fill,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overflow,
  input  logic                        clr_err
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3, S_BREAK = 3'd4, S_PARITY = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3, S_BREAK = 3'd4
  } state_t;
`endif

  state_t                 state, state_nx;
  logic [1:0]             sync;
  logic                   rx_s;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [DATA_BITS-1:0]   shift;
  logic                   tick;
  logic                   push, ferr_set;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [FW-1:0]          count;
  logic                   pop, full, wr_en, drop;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic                   par_bad;
  logic                   perr_set;
`endif

  assign rx_s = sync[1];
  // Bit-time tick: half a bit during START to land on bit centres, full bit otherwise.
  assign tick = (state == S_START) ? (cnt == HALF_M1) : (cnt == FULL_M1);

  // Two-flop synchroniser for the asynchronous serial line; resets to idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], rx_pin};
  end

  // Receive FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Receive FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (!rx_s) state_nx = S_START;
      S_START:  if (tick) state_nx = rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:   if (tick && idx == LAST_IDX) state_nx = S_PARITY;
      S_PARITY: if (tick) state_nx = S_STOP;
`else
      S_DATA:   if (tick && idx == LAST_IDX) state_nx = S_STOP;
`endif
      S_STOP:   if (tick) state_nx = rx_s ? S_IDLE : S_BREAK;
      S_BREAK:  if (rx_s) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Receive FSM outputs: decide the fate of the frame at the stop-bit sample.
  always_comb begin
    push     = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_set = 1'b0;
`endif
    if (state == S_STOP && tick) begin
      if (!rx_s)        ferr_set = 1'b1;
`ifdef UART_RX_PARITY_EN
      else if (par_bad) perr_set = 1'b1;
`endif
      else              push     = 1'b1;
    end
  end

  // Bit timer, bit index and LSB-first shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      if (state_nx != state || tick || state == S_IDLE || state == S_BREAK) cnt <= '0;
      else                                                                  cnt <= cnt + 1'b1;
      if (state == S_START)             idx <= '0;
      else if (state == S_DATA && tick) idx <= idx + 1'b1;
      if (state == S_DATA && tick)      shift <= {rx_s, shift[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity verdict latched at the parity-bit sample, cleared for every new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         par_bad <= 1'b0;
    else if (state == S_START)          par_bad <= 1'b0;
    else if (state == S_PARITY && tick) par_bad <= ((^shift) ^ rx_s) != PAR_ODD;
  end

  // Parity error pulse, one cycle after the failing stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= perr_set;
  end
`else
  assign parity_err = 1'b0;
`endif

  // Framing error pulse, one cycle after the low stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= ferr_set;
  end

  // FIFO control: a pop in the same cycle frees the slot a full-FIFO push needs.
  assign pop   = m_ready && (count != '0);
  assign full  = (count == FW'(FIFO_DEPTH));
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shift;
  end

  // Sticky overflow; a drop coinciding with clr_err keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_err) overflow <= 1'b0;
  end

  assign m_data  = mem[rd_ptr];
  assign m_valid = (count != '0);
  assign fill    = count;

endmodule
